// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sharing the transmitter's 20-bit baud divisor and enable.
// Samples each bit at its midpoint and emits a one-cycle valid or framing-error strobe.
module uart_rx (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic [19:0] i_baud,
    input  logic        i_rx,
    output logic [7:0]  o_dout,
    output logic        o_rx_valid,
    output logic        o_frame_err,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t      r_state, w_state_next;
    logic        r_rx_m, r_rx_s, r_rx_prev;
    logic [19:0] r_baud_q, r_cnt;
    logic [3:0]  r_idx;
    logic [7:0]  r_shreg;
    logic        w_fall, w_valid_baud, w_abort, w_half_hit, w_bit_hit;
    logic [19:0] w_half;

    assign w_fall       = r_rx_prev & ~r_rx_s;
    assign w_valid_baud = i_baud >= 20'd15;
    assign w_abort      = ~i_sel | ~w_valid_baud;
    assign w_half       = r_baud_q >> 1;
    assign w_half_hit   = r_cnt == w_half - 20'd1;
    assign w_bit_hit    = r_cnt == r_baud_q - 20'd1;
    assign o_busy       = r_state != IDLE;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = (i_sel & w_valid_baud & w_fall) ? START : IDLE;
            START:   w_state_next = w_half_hit ? (r_rx_s ? IDLE : DATA) : START;
            DATA:    w_state_next = (w_bit_hit && r_idx == 4'd7) ? STOP : DATA;
            STOP:    w_state_next = w_bit_hit ? IDLE : STOP;
            default: w_state_next = IDLE;
        endcase
        // Losing the enable or a valid divisor drops any frame in progress.
        if (r_state != IDLE && w_abort)
            w_state_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_m      <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_baud_q    <= 20'd0;
            r_cnt       <= 20'd0;
            r_idx       <= 4'd0;
            r_shreg     <= 8'd0;
            o_dout      <= 8'd0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            {r_rx_prev, r_rx_s, r_rx_m} <= {r_rx_s, r_rx_m, i_rx};
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            if (r_state == IDLE) begin
                if (w_state_next == START) begin
                    r_cnt    <= 20'd0;
                    r_baud_q <= i_baud;
                end
            end else if (!w_abort) begin
                case (r_state)
                    START: begin
                        if (w_half_hit) begin
                            r_cnt <= 20'd0;
                            r_idx <= 4'd0;
                        end else
                            r_cnt <= r_cnt + 20'd1;
                    end
                    DATA: begin
                        if (w_bit_hit) begin
                            r_shreg <= {r_rx_s, r_shreg[7:1]};
                            r_cnt   <= 20'd0;
                            r_idx   <= r_idx + 4'd1;
                        end else
                            r_cnt <= r_cnt + 20'd1;
                    end
                    STOP: begin
                        if (w_bit_hit) begin
                            r_cnt <= 20'd0;
                            if (r_rx_s) begin
                                o_dout     <= r_shreg;
                                o_rx_valid <= 1'b1;
                            end else
                                o_frame_err <= 1'b1;
                        end else
                            r_cnt <= r_cnt + 20'd1;
                    end
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a per-cycle timeline of expected busy/strobe/dout.
// Expectations are derived from frame start time, latched divisor and the mid-bit sampling rule.
module tb_uart_rx;
    localparam int MAXC = 40000;

    logic        clk, rst, sel, rx;
    logic [19:0] baud;
    logic [7:0]  dout;
    logic        rx_valid, frame_err, busy;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    bit          exp_busy  [MAXC];
    bit          exp_valid [MAXC];
    bit          exp_ferr  [MAXC];
    logic [7:0]  exp_byte  [MAXC];
    logic [7:0]  model_dout = 8'd0;

    uart_rx dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_baud(baud), .i_rx(rx),
        .o_dout(dout), .o_rx_valid(rx_valid), .o_frame_err(frame_err), .o_busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // A frame whose start edge is driven just after edge n enters START at n+3.
    task automatic sched(input int n, input int bd, input logic [7:0] b, input bit stop);
        int d, s;
        d = n + 3;
        s = d + bd / 2 + 9 * bd;
        for (int m = d; m < s; m++) exp_busy[m] = 1'b1;
        if (stop) begin
            exp_valid[s] = 1'b1;
            exp_byte[s]  = b;
        end else
            exp_ferr[s] = 1'b1;
    endtask

    task automatic truncate(input int from);
        for (int m = from; m < MAXC; m++) begin
            exp_busy[m]  = 1'b0;
            exp_valid[m] = 1'b0;
            exp_ferr[m]  = 1'b0;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop, input int bd, input bit expect_rx);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (expect_rx) sched(cyc, bd, b, stop);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (bd) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && cyc < MAXC) begin
            if (exp_valid[cyc]) model_dout = exp_byte[cyc];
            check("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
            check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid[cyc]});
            check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr[cyc]});
            check("dout", {24'd0, dout}, {24'd0, model_dout});
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        int         bd;
        bit         stop;
        rst = 1'b1; sel = 1'b0; rx = 1'b1; baud = 20'd16;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; sel = 1'b1; mon_en = 1'b1;
        idle(5);

        drive_frame(8'h55, 1'b1, 16, 1'b1);
        idle(4);

        baud = 20'd20;
        drive_frame(8'hA3, 1'b1, 20, 1'b1);
        drive_frame(8'h0F, 1'b1, 20, 1'b1);
        idle(4);

        baud = 20'd16;
        drive_frame(8'h3C, 1'b0, 16, 1'b1);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(5);
        drive_frame(8'h96, 1'b1, 16, 1'b1);
        idle(4);

        for (int m = cyc + 3; m < cyc + 11; m++) exp_busy[m] = 1'b1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(20);

        baud = 20'd14;
        drive_frame(8'h81, 1'b1, 14, 1'b0);
        idle(4);
        baud = 20'd16;

        fork
            drive_frame(8'($urandom), 1'b1, 16, 1'b1);
            begin
                repeat (30 + $urandom_range(0, 100)) @(posedge clk);
                #1 sel = 1'b0;
                truncate(cyc + 1);
            end
        join
        sel = 1'b1;
        idle(4);

        fork
            drive_frame(8'($urandom), 1'b1, 16, 1'b1);
            begin
                repeat (30 + $urandom_range(0, 100)) @(posedge clk);
                #1 baud = 20'd10;
                truncate(cyc + 1);
            end
        join
        baud = 20'd16;
        idle(4);

        fork
            drive_frame(8'hFF, 1'b1, 16, 1'b1);
            begin
                repeat (3 + 8 + 16 * 3) @(posedge clk);
                #2 rst = 1'b1;
                truncate(cyc);
                model_dout = 8'd0;
                #1;
                check("mid_rst_dout", {24'd0, dout}, 32'd0);
                check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
                check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
                check("mid_rst_busy", {31'd0, busy}, 32'd0);
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle(4);

        fork
            drive_frame(8'hC6, 1'b1, 16, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #1 baud = 20'd32;
            end
        join
        baud = 20'd16;
        idle(4);

        for (int k = 0; k < 16; k++) begin
            bd = $urandom_range(15, 40);
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            baud = 20'(bd);
            drive_frame(b, stop, bd, 1'b1);
            if (!stop) idle(4);
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
        end
        idle(50);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver for the uart_binary subsystem, the receive-side counterpart of the transmit control path. It samples the serial `rx` line using the same 20-bit `baud` divisor and `sel` enable that drive the transmitter, so one register setting configures both directions. Each frame is 1 start bit, 8 data bits LSB-first, and 1 stop bit. It delivers each received byte with a one-cycle `rx_valid` strobe, or flags a framing error.

## Interface
- No parameters. Frame format is fixed at 8N1.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `sel`  input  1  receiver enable; 0 forces IDLE.
- `baud`  input  20  clock cycles per bit; a value is valid only if it is ≥ 15.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `dout`  output  8  last correctly framed byte.
- `rx_valid`  output  1  one-cycle strobe: `dout` was updated this cycle.
- `frame_err`  output  1  one-cycle strobe: the stop bit sampled 0.
- `busy`  output  1  high when the state is not IDLE.

## Operation
- **Synchronizer:** `rx` passes through two flops to give `rx_s`. `rx_prev` is `rx_s` delayed one cycle. All three reset to 1.
- **Falling edge:** `fall = rx_prev & ~rx_s`.
- **valid_baud:** `baud >= 15`.
- **Baud latch:** `baud` is captured into `baud_q` on the IDLE→START transition. Changes to `baud` during a frame are ignored. `half = baud_q >> 1`.
- **Counters:** 20-bit cycle counter `cnt` and 4-bit bit index `idx`.
- **IDLE:**
  - If `sel & valid_baud & fall`: go to START, `cnt <= 0`.
  - Otherwise stay in IDLE.
  - A line held low (break, or after a framing error) does not re-trigger. A new frame needs a fresh 1→0 edge.
- **START:**
  - While `cnt != half-1`: `cnt++`.
  - At `cnt == half-1` (mid start bit):
    - If `rx_s == 0`: go to DATA, `cnt <= 0`, `idx <= 0`.
    - Otherwise the event was a glitch: go to IDLE with no strobe.
- **DATA:**
  - While `cnt != baud_q-1`: `cnt++`.
  - At `cnt == baud_q-1`: `shreg <= {rx_s, shreg[7:1]}`, `cnt <= 0`, `idx++`.
  - After the 8th sample (`idx == 7` at the sample point): go to STOP.
- **STOP:**
  - At `cnt == baud_q-1`, sample `rx_s`:
    - If 1: `dout <= shreg` and `rx_valid <= 1`.
    - If 0: `frame_err <= 1`; `dout` is unchanged.
  - Then go to IDLE.
- **Abort:** `sel == 0` or `valid_baud == 0` in any non-IDLE state forces IDLE on the next edge. No strobe is issued and `dout` is unchanged. The abort has priority over every other transition.
- **Strobes:** `rx_valid` and `frame_err` are registered, high for exactly one cycle, and never high together.
- **Reset values:** state IDLE; `dout = 0`; `rx_valid = 0`; `frame_err = 0`; `busy = 0`; `cnt = 0`; `idx = 0`; `shreg = 0`. Reset mid-frame discards the frame and clears all outputs immediately.

## Timing
- **Edge detection:** a 1→0 transition on `rx` that settles before clock edge k produces `fall` during the cycle after edge k+1. The FSM enters START at edge k+2, called edge D.
- **Start check:** at edge D+half.
- **Data bit i (i = 0..7):** sampled at edge D+half+(i+1)·baud_q.
- **Stop bit:** sampled at edge D+half+9·baud_q. At that edge `rx_valid` or `frame_err` rises, and it falls at the following edge.
- **busy:** rises at edge D and falls at the stop-sample edge.
- **Back-to-back frames:** the IDLE edge detector is live on the cycle after the stop sample. A next start edge arriving half a bit after the stop midpoint is therefore accepted.
- **Tolerance:** sampling is at mid-bit ±1 cycle of synchronizer jitter. With `baud ≥ 15` this is at least ±7 cycles of margin per bit.

## Test plan
- **Nominal byte:** `baud` = 16, `sel` = 1, drive frame 0x55 with stop = 1 → `rx_valid` high 1 cycle at D+8+144, `dout` = 0x55, `frame_err` = 0.
- **Back-to-back frames:** frames 0xA3 then 0x0F with no idle gap, `baud` = 20 → two `rx_valid` strobes, `dout` = 0xA3 then 0x0F.
- **Framing error:** frame 0x3C with stop bit = 0 → `frame_err` high 1 cycle, `rx_valid` = 0, `dout` keeps its prior value. A line then held low produces no further activity until `rx` goes high and falls again.
- **Glitch rejection:** `rx` low for 4 cycles at `baud` = 16 → START aborts at the half-bit check, `busy` high for 8 cycles, no strobes.
- **Invalid baud / disabled:** `baud` = 14 with a valid frame → `busy` stays 0, no strobes. `sel` dropped mid-frame → IDLE on the next edge, no strobe.
- **Reset mid-frame and baud latch:** assert `rst` during DATA → all outputs 0 immediately, no strobe after release. Separately, change `baud` 16→32 mid-frame → the frame completes at 16 cycles per bit with the correct byte.
